serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 119 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first ripple over WIDTH cycles with valid/ready handshakes.
// Define SERIAL_ADDER_SUB_EN to add a Sub input selecting A - B (Carry=1 means no borrow).
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             Sub,
`endif
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry,
   output logic             busy
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   logic             sum_bit;
   logic [WIDTH-1:0] b_in;
   logic             c_in;

   // Subtraction is A + ~B + 1; the inversion is applied once at acceptance.
`ifdef SERIAL_ADDER_SUB_EN
   assign b_in = Sub ? ~B : B;
   assign c_in = Sub ? 1'b1 : Cin;
`else
   assign b_in = B;
   assign c_in = Cin;
`endif

   assign sum_bit = a_q[0] ^ b_q[0] ^ carry_q;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = A;
               b_d     = b_in;
               carry_d = c_in;
               sum_d   = '0;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            sum_d   = {sum_bit, sum_q[WIDTH-1:1]};
            carry_d = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            // Hold the counter on the final bit so it never wraps.
            if (cnt_q == LastBit) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      in_ready  = (state_q == StIdle);
      busy      = (state_q == StRun);
      out_valid = (state_q == StDone);
      Sum       = sum_q;
      Carry     = carry_q;
   end

endmodule
